uart_slot_readback_responder: RTL and testbench

- SPI read-path responder: the counterpart to the UART slot-select write path.
- Decodes a `C_GET_UART_SLOT` read command addressed to `UART_CONTROLLER_ADDRESS`.
- Snapshots the current UART slot selection into a 40-bit response frame and shifts it out MSB-first on the SPI SDO line, one bit per SCK falling-edge strobe from the SPI front end.
- Sits beside the UART slot controller, fed by the same registered SPI command bus.

---
 rtl/uart_slot_readback_responder_pkg.sv | 19 +
 rtl/uart_slot_readback_responder_crc.sv | 27 ++
 rtl/uart_slot_readback_responder.sv | 138 +++++++++++++
 tb/tb_uart_slot_readback_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_slot_readback_responder_pkg.sv
// Shared command/address constants and state type for the UART slot
// read-back path (the SV home of the old commands.v defines).
//   C_GET_UART_SLOT          read-slot command word
//   UART_CONTROLLER_ADDRESS  SPI target address of the UART controller
//   UART_RESP_MARKER         7-bit marker at the head of every response
//   UART_RESP_CRC_POLY       CRC-8 polynomial used when UART_RESP_CRC_EN is set
package uart_slot_readback_responder_pkg;

    localparam logic [15:0] C_GET_UART_SLOT         = 16'h00A7;
    localparam logic [7:0]  UART_CONTROLLER_ADDRESS = 8'h3C;
    localparam logic [6:0]  UART_RESP_MARKER        = 7'b1010010;
    localparam logic [7:0]  UART_RESP_CRC_POLY      = 8'h07;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } resp_state_t;

endpackage

// File: rtl/uart_slot_readback_responder_crc.sv
// crc8_calc: combinational CRC-8 (poly UART_RESP_CRC_POLY, init 0, no
// reflection, no final XOR) over a 32-bit word, MSB first.
// Only instantiated when UART_RESP_CRC_EN is defined.
//   data  in   32  payload, bit 31 processed first
//   crc   out  8   resulting CRC
module crc8_calc
    import uart_slot_readback_responder_pkg::*;
(
    input  logic [31:0] data,
    output logic [7:0]  crc
);

    logic [7:0] acc;

    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (acc[7] ^ data[5'(31 - i)]) begin
                acc = {acc[6:0], 1'b0} ^ UART_RESP_CRC_POLY;
            end else begin
                acc = {acc[6:0], 1'b0};
            end
        end
        crc = acc;
    end

endmodule

// File: rtl/uart_slot_readback_responder.sv
// uart_slot_readback_responder: answers a C_GET_UART_SLOT read addressed to
// UART_CONTROLLER_ADDRESS by snapshotting uart_slot_en into a 40-bit frame
// and shifting it out MSB-first on spi_sdo, one bit per SCK falling strobe.
// Frame: {marker[6:0], overrun, addr[7:0], slot zero-extended[15:0], crc[7:0]}.
// Optional: define UART_RESP_CRC_EN to fill frame[7:0] with CRC-8 of
// frame[39:8]; otherwise frame[7:0] is zero.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   spi_cmd_r/addr_r     registered SPI command / target address
//   spi_data_valid_r     one-cycle strobe qualifying cmd/addr
//   spi_cs_active        chip select (synchronised, active-high)
//   spi_sck_fall         one-cycle strobe per SCK falling edge
//   uart_slot_en         slot selection to report
//   spi_sdo              serial response bit
//   resp_busy            frame loaded / shifting
//   resp_done            one-cycle pulse after the last bit
//   resp_abort           one-cycle pulse when CS drops mid-frame
module uart_slot_readback_responder
    import uart_slot_readback_responder_pkg::*;
#(
    parameter int UART_ADDRESS_WIDTH = 4,
    parameter int FRAME_BITS         = 40
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [15:0]                   spi_cmd_r,
    input  logic [7:0]                    spi_addr_r,
    input  logic                          spi_data_valid_r,
    input  logic                          spi_cs_active,
    input  logic                          spi_sck_fall,
    input  logic [UART_ADDRESS_WIDTH-1:0] uart_slot_en,
    output logic                          spi_sdo,
    output logic                          resp_busy,
    output logic                          resp_done,
    output logic                          resp_abort
);

    resp_state_t           state, state_n;
    logic [5:0]            cnt, cnt_n;
    logic [FRAME_BITS-1:0] shreg, shreg_n;
    logic                  overrun, overrun_n;
    logic                  done_n, abort_n;

    logic                  match;
    logic [15:0]           slot16;
    logic [31:0]           payload;
    logic [7:0]            crc;
    logic [FRAME_BITS-1:0] frame;

    assign match = spi_data_valid_r
                && (spi_cmd_r == C_GET_UART_SLOT)
                && (spi_addr_r == UART_CONTROLLER_ADDRESS);

    // Zero-extend without a replication that would be zero-width at 16.
    always_comb begin
        slot16 = '0;
        slot16[UART_ADDRESS_WIDTH-1:0] = uart_slot_en;
    end

    assign payload = {UART_RESP_MARKER, overrun, spi_addr_r, slot16};

`ifdef UART_RESP_CRC_EN
    crc8_calc u_crc8_calc (
        .data (payload),
        .crc  (crc)
    );
`else
    assign crc = '0;
`endif

    assign frame = {payload, crc};

    // The line is only driven while a frame is in flight.
    assign spi_sdo   = (state == SHIFT) && shreg[FRAME_BITS-1];
    assign resp_busy = (state == SHIFT);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        overrun_n = overrun;
        done_n    = 1'b0;
        abort_n   = 1'b0;
        case (state)
            IDLE: begin
                // A coincident SCK strobe is ignored: bit 39 is presented first.
                if (match) begin
                    shreg_n   = frame;
                    cnt_n     = '0;
                    overrun_n = 1'b0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (match) begin
                    overrun_n = 1'b1;
                end
                // CS loss wins over a simultaneous final strobe.
                if (!spi_cs_active) begin
                    state_n = IDLE;
                    shreg_n = '0;
                    cnt_n   = '0;
                    abort_n = 1'b1;
                end else if (spi_sck_fall) begin
                    shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
                    if (cnt == 6'(FRAME_BITS - 1)) begin
                        state_n = IDLE;
                        shreg_n = '0;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            overrun    <= 1'b0;
            resp_done  <= 1'b0;
            resp_abort <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            overrun    <= overrun_n;
            resp_done  <= done_n;
            resp_abort <= abort_n;
        end
    end

endmodule

// File: tb/tb_uart_slot_readback_responder.sv
// Scoreboard bench for uart_slot_readback_responder. Stimulus tasks keep a
// transaction-level model (busy / strobe count / sticky overrun) and push the
// expected frame and expected ending into queues; a negedge monitor
// reassembles the serial word and checks it when done/abort is seen.
module tb_uart_slot_readback_responder;
    import uart_slot_readback_responder_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [15:0]  spi_cmd_r;
    logic [7:0]   spi_addr_r;
    logic         spi_data_valid_r;
    logic         spi_cs_active;
    logic         spi_sck_fall;
    logic [W-1:0] uart_slot_en;
    logic         spi_sdo, resp_busy, resp_done, resp_abort;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_slot_readback_responder #(
        .UART_ADDRESS_WIDTH (W),
        .FRAME_BITS         (40)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .spi_cmd_r        (spi_cmd_r),
        .spi_addr_r       (spi_addr_r),
        .spi_data_valid_r (spi_data_valid_r),
        .spi_cs_active    (spi_cs_active),
        .spi_sck_fall     (spi_sck_fall),
        .uart_slot_en     (uart_slot_en),
        .spi_sdo          (spi_sdo),
        .resp_busy        (resp_busy),
        .resp_done        (resp_done),
        .resp_abort       (resp_abort)
    );

    typedef struct {
        bit is_done;
        int nstrobes;
    } end_t;

    logic [39:0] frame_q[$];
    end_t        end_q[$];

    // Transaction-level model state
    bit m_busy = 0;
    bit m_ovr  = 0;
    int m_cnt  = 0;
    bit cs_level = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC-8 as polynomial long division of {data, 8'h00} by x^8+x^2+x+1.
    function automatic logic [7:0] ref_crc(input logic [31:0] d);
        logic [39:0] r;
        r = {d, 8'h00};
        for (int b = 39; b >= 8; b--) begin
            if (r[b]) r[b -: 9] = r[b -: 9] ^ 9'h107;
        end
        return r[7:0];
    endfunction

    function automatic logic [39:0] ref_frame(input bit ovr, input logic [W-1:0] slot);
        logic [31:0] hi;
        logic [7:0]  lo;
        hi = {7'b1010010, ovr, UART_CONTROLLER_ADDRESS, 16'(slot)};
`ifdef UART_RESP_CRC_EN
        lo = ref_crc(hi);
`else
        lo = 8'h00;
`endif
        return {hi, lo};
    endfunction

    // Drive one clock cycle of inputs and advance the model over that edge.
    task automatic cycle(input bit v, input logic [15:0] cmd, input logic [7:0] addr,
                         input bit sck, input bit cs);
        bit mtch;
        end_t e;
        spi_data_valid_r = v;
        spi_cmd_r        = cmd;
        spi_addr_r       = addr;
        spi_sck_fall     = sck;
        spi_cs_active    = cs;
        mtch = v && (cmd == C_GET_UART_SLOT) && (addr == UART_CONTROLLER_ADDRESS);
        if (m_busy) begin
            if (mtch) m_ovr = 1;
            if (!cs) begin
                e.is_done = 0; e.nstrobes = m_cnt;
                end_q.push_back(e);
                m_busy = 0;
            end else if (sck) begin
                m_cnt++;
                if (m_cnt == 40) begin
                    e.is_done = 1; e.nstrobes = 40;
                    end_q.push_back(e);
                    m_busy = 0;
                end
            end
        end else if (mtch) begin
            frame_q.push_back(ref_frame(m_ovr, uart_slot_en));
            m_ovr  = 0;
            m_busy = 1;
            m_cnt  = 0;
        end
        @(posedge clk);
        #1;
        spi_data_valid_r = 1'b0;
        spi_sck_fall     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 8'h0, 0, cs_level);
    endtask

    task automatic do_match();
        cycle(1, C_GET_UART_SLOT, UART_CONTROLLER_ADDRESS, 0, cs_level);
    endtask

    task automatic strobe();
        idle($urandom_range(0, 2));
        cycle(0, 16'h0, 8'h0, 1, cs_level);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) strobe();
    endtask

    task automatic cs_drop();
        cs_level = 0;
        idle(2);
        cs_level = 1;
        idle(1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sdo"},   spi_sdo,    0);
        check({tag, "_busy"},  resp_busy,  0);
        check({tag, "_done"},  resp_done,  0);
        check({tag, "_abort"}, resp_abort, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if (m_busy) void'(frame_q.pop_back());
        m_busy = 0; m_ovr = 0; m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: collects one bit at load and one after each accepted strobe.
    bit          prev_busy = 0, prev_acc = 0;
    logic [39:0] cap = '0;
    int          ncap = 0;
    logic [39:0] mf;
    end_t        me;

    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 0; prev_acc = 0; cap = '0; ncap = 0;
        end else begin
            if (resp_done || resp_abort) begin
                if (frame_q.size() == 0 || end_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pulse: got done=%0b abort=%0b expected none at %0t",
                             resp_done, resp_abort, $time);
                end else begin
                    mf = frame_q.pop_front();
                    me = end_q.pop_front();
                    check("end_is_done", resp_done, me.is_done);
                    check("end_is_abort", resp_abort, !me.is_done);
                    if (me.is_done) begin
                        check("frame_bits", ncap, 40);
                        check("frame_word", cap, mf);
                    end else begin
                        check("abort_bits", ncap, me.nstrobes + 1);
                        check("abort_prefix", cap, mf >> (39 - me.nstrobes));
                    end
                end
                cap = '0; ncap = 0;
            end
            if (!resp_busy) begin
                check("idle_sdo", spi_sdo, 0);
            end else if (!prev_busy || prev_acc) begin
                cap = {cap[38:0], spi_sdo};
                ncap++;
            end else begin
                check("sdo_hold", spi_sdo, cap[0]);
            end
            prev_acc  = resp_busy && spi_sck_fall && spi_cs_active;
            prev_busy = resp_busy;
        end
    end

`ifdef UART_RESP_CRC_EN
    logic [31:0] crc_in;
    logic [7:0]  crc_out;
    crc8_calc u_crc_chk (
        .data (crc_in),
        .crc  (crc_out)
    );
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset = 1'b1;
        spi_cmd_r = '0; spi_addr_r = '0; spi_data_valid_r = 0;
        spi_cs_active = 1; spi_sck_fall = 0; uart_slot_en = 4'h9;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_quiet("reset");

        // Plain read of slot 9
        uart_slot_en = 4'h9;
        do_match();
        strobes(40);
        idle(2);

        // CS drop after 17 strobes, then a fresh read
        do_match();
        strobes(17);
        cs_drop();
        do_match();
        strobes(40);
        idle(2);

        // Overrun: second match mid-frame -> next frame A5, then A4
        do_match();
        strobes(5);
        do_match();
        strobes(35);
        cs_drop();
        do_match();
        strobes(40);
        idle(1);
        do_match();
        strobes(40);
        idle(2);

        // Coincident strobe ignored, slot change mid-shift ignored
        uart_slot_en = 4'h9;
        cycle(1, C_GET_UART_SLOT, UART_CONTROLLER_ADDRESS, 1, 1);
        idle(3);
        strobes(10);
        uart_slot_en = 4'h3;
        strobes(30);
        idle(2);

        // Reset at strobe 20: no pulses, all outputs back to 0
        do_match();
        strobes(20);
        do_reset();
        check_quiet("midreset");
        idle(3);

        // Non-matching commands and idle strobes
        cycle(1, C_GET_UART_SLOT, UART_CONTROLLER_ADDRESS ^ 8'h01, 0, 1);
        check("wrong_addr_busy", resp_busy, 0);
        cycle(1, C_GET_UART_SLOT ^ 16'h0001, UART_CONTROLLER_ADDRESS, 0, 1);
        check("wrong_cmd_busy", resp_busy, 0);
        cycle(0, 16'h0, 8'h0, 1, 0);
        cycle(0, 16'h0, 8'h0, 1, 1);
        check("idle_strobe_busy", resp_busy, 0);
        idle(2);

        // Randomised traffic
        for (int t = 0; t < 25; t++) begin
            uart_slot_en = W'($urandom);
            do_match();
            for (int k = 0; k < 200 && m_busy; k++) begin
                r = $urandom_range(0, 99);
                if (r < 2) begin
                    cs_level = 0; idle(1); cs_level = 1;
                end else if (r < 4) begin
                    cycle(0, 16'h0, 8'h0, 1, 0);
                end else begin
                    if (r < 8) uart_slot_en = W'($urandom);
                    idle($urandom_range(0, 1));
                    cycle(r < 14, C_GET_UART_SLOT, UART_CONTROLLER_ADDRESS, 1, 1);
                end
            end
            idle($urandom_range(1, 3));
        end

`ifdef UART_RESP_CRC_EN
        crc_in = '0;
        #1;
        check("crc_zero", crc_out, 8'h00);
        for (int i = 0; i < 6; i++) begin
            crc_in = $urandom;
            #1;
            check("crc_random", crc_out, ref_crc(crc_in));
        end
`endif

        idle(4);
        check("frame_q_empty", frame_q.size(), 0);
        check("end_q_empty", end_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
